// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter on the MIPS data bus:
// register offsets, STATUS bit positions and the transmit FSM state type.
package mips_io_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic busy, input logic full,
                                                input logic empty, input logic ovf,
                                                input logic [7:0] count);
        logic [31:0] w;
        w = 32'd0;
        w[ST_BUSY]              = busy;
        w[ST_FULL]              = full;
        w[ST_EMPTY]             = empty;
        w[ST_OVF]               = ovf;
        w[ST_COUNT_LSB +: 8]    = count;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the UART: store strobe, address, write data, and the
// read data / select pair the top level muxes against data memory.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sel;

    modport master (output memwrite, output adr, output writedata,
                    input readdata, input sel);
    modport slave  (input memwrite, input adr, input writedata,
                    output readdata, output sel);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes core stores into a TX FIFO and
// serialises bytes LSB first on txd; STATUS/CTRL are readable over the bus.
module mmio_uart_tx
    import mips_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          irq_empty
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          sel_s;
    logic          wr_s;
    logic [1:0]    off_s;
    logic          push_req_s;
    logic          ovf_clr_s;
    logic          ctrl_wr_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    fifo_rdata_s;
    logic          pop_s;

    logic          en_r;
    logic          ovf_r;
    tx_state_t     state_r;
    tx_state_t     state_nxt_s;
    logic [BW-1:0] baud_r;
    logic [BW-1:0] baud_nxt_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          baud_end_s;
    logic          txd_r;
    logic          txd_nxt_s;

    assign sel_s      = (bus.adr[31:4] == BASE_ADDR[31:4]);
    assign off_s      = bus.adr[3:2];
    assign wr_s       = bus.memwrite && sel_s;
    assign push_req_s = wr_s && (off_s == OFF_TXDATA);
    assign ovf_clr_s  = wr_s && (off_s == OFF_STATUS) && bus.writedata[ST_OVF];
    assign ctrl_wr_s  = wr_s && (off_s == OFF_CTRL);
    assign unused_s   = ^{bus.adr[1:0], bus.writedata[31:8]};

    assign bus.sel      = sel_s;
    assign bus.readdata = rdata_s;
    assign txd          = txd_r;
    assign irq_empty    = fifo_empty_s && (state_r == IDLE) && en_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata (bus.writedata[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Register read mux; unselected or reserved offsets return zero.
    always_comb begin
        rdata_s = 32'd0;
        if (sel_s) begin
            case (off_s)
                OFF_STATUS: rdata_s = status_word(state_r != IDLE, fifo_full_s, fifo_empty_s,
                                                  ovf_r, 8'(fifo_count_s));
                OFF_CTRL:   rdata_s = {31'd0, en_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // CTRL.EN and the sticky overflow flag (a push that is matched by a pop is not an overflow).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                en_r <= bus.writedata[0];
            end
            if (push_req_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Transmit FSM next state; txd is registered from the next-state view so it lines up with state.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        txd_nxt_s     = 1'b1;
        baud_end_s    = (baud_r == BAUD_LAST);
        case (state_r)
            IDLE: begin
                if (en_r && !fifo_empty_s) begin
                    pop_s         = 1'b1;
                    shift_nxt_s   = fifo_rdata_s;
                    bit_idx_nxt_s = 3'd0;
                    baud_nxt_s    = BW'(0);
                    state_nxt_s   = START;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_nxt_s  = BW'(0);
                    state_nxt_s = DATA;
                end else begin
                    baud_nxt_s  = baud_r + BW'(1);
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_nxt_s    = BW'(0);
                    shift_nxt_s   = {1'b0, shift_r[7:1]};
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    baud_nxt_s    = baud_r + BW'(1);
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_nxt_s = BW'(0);
                    if (en_r && !fifo_empty_s) begin
                        pop_s         = 1'b1;
                        shift_nxt_s   = fifo_rdata_s;
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = START;
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r + BW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                baud_nxt_s  = BW'(0);
            end
        endcase
        case (state_nxt_s)
            START:   txd_nxt_s = 1'b0;
            DATA:    txd_nxt_s = shift_nxt_s[0];
            default: txd_nxt_s = 1'b1;
        endcase
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            baud_r    <= BW'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            txd_r     <= txd_nxt_s;
        end
    end

endmodule
